// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among several valid/ready producers.
// Grants last up to G_BURST beats and never write into a full FIFO.
module fifo_wr_arbiter #(
    parameter int G_WIDTH   = 8,
    parameter int G_NUM_REQ = 4,
    parameter int G_BURST   = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [G_NUM_REQ-1:0]         i_req_valid,
    input  logic [G_NUM_REQ*G_WIDTH-1:0] i_req_data,
    output logic [G_NUM_REQ-1:0]         o_req_ready,
    output logic [G_NUM_REQ-1:0]         o_gnt,
    output logic                         o_busy,
    output logic                         o_fifo_wr,
    output logic [G_WIDTH-1:0]           o_fifo_data,
    input  logic                         i_fifo_full
);

    localparam int PTR_W = $clog2(G_NUM_REQ);
    localparam int CNT_W = $clog2(G_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 r_state, nxt_state;
    logic [G_NUM_REQ-1:0]   r_gnt, nxt_gnt;
    logic [PTR_W-1:0]       r_ptr, nxt_ptr;
    logic [CNT_W-1:0]       r_cnt, nxt_cnt;

    logic [PTR_W-1:0]       gnt_idx;
    logic [G_WIDTH-1:0]     data_mux;
    logic                   gnt_valid;
    logic                   beat;
    logic                   burst_done;

    // First valid requester after p, wrapping round and ending at p itself.
    function automatic logic [G_NUM_REQ-1:0] select_next(
        input logic [PTR_W-1:0]     p,
        input logic [G_NUM_REQ-1:0] v
    );
        logic [G_NUM_REQ-1:0] sel;
        logic [PTR_W-1:0]     idx;
        logic                 found;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= G_NUM_REQ; i++) begin
            idx = PTR_W'((int'(p) + i) % G_NUM_REQ);
            if (!found && v[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return sel;
    endfunction

    assign o_req_ready = r_gnt & {G_NUM_REQ{~i_fifo_full}};
    assign beat        = |(i_req_valid & o_req_ready);
    assign o_fifo_wr   = beat;
    assign o_fifo_data = data_mux;
    assign o_gnt       = r_gnt;
    assign o_busy      = (r_state == GRANT);
    assign gnt_valid   = |(i_req_valid & r_gnt);
    assign burst_done  = beat && ((r_cnt + CNT_W'(1)) == CNT_W'(G_BURST));

    always_comb begin
        gnt_idx  = '0;
        data_mux = '0;
        for (int k = 0; k < G_NUM_REQ; k++) begin
            if (r_gnt[k]) begin
                gnt_idx  = PTR_W'(k);
                data_mux = i_req_data[k*G_WIDTH +: G_WIDTH];
            end
        end
    end

    always_comb begin
        nxt_state = r_state;
        nxt_gnt   = r_gnt;
        nxt_ptr   = r_ptr;
        nxt_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                nxt_gnt = '0;
                if (|i_req_valid) begin
                    nxt_gnt   = select_next(r_ptr, i_req_valid);
                    nxt_cnt   = '0;
                    nxt_state = GRANT;
                end
            end
            GRANT: begin
                // Release on burst limit or on the grantee dropping valid; rotate from the grantee.
                if (burst_done || !gnt_valid) begin
                    nxt_ptr = gnt_idx;
                    nxt_cnt = '0;
                    nxt_gnt = select_next(gnt_idx, i_req_valid);
                    if (!(|i_req_valid)) begin
                        nxt_state = IDLE;
                    end
                end else if (beat) begin
                    nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_gnt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= PTR_W'(G_NUM_REQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= nxt_state;
            r_gnt   <= nxt_gnt;
            r_ptr   <= nxt_ptr;
            r_cnt   <= nxt_cnt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a queue-based round-robin model.
module tb_fifo_wr_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int B = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     valid;
    logic [N*W-1:0]   data;
    logic [N-1:0]     ready;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             wr;
    logic [W-1:0]     fdata;
    logic             full;

    typedef struct {
        logic [N-1:0] gnt;
        logic [N-1:0] ready;
        logic         busy;
    } ctl_t;

    ctl_t         ctl_q[$];
    logic [W-1:0] data_q[$];
    int           checks = 0;
    int           passes = 0;

    // Reference model state: current grantee (-1 = none), last grantee, beats in grant.
    int           cur;
    int           last;
    int           beats;
    int           seq[N];
    logic [N-1:0] pend;

    fifo_wr_arbiter #(.G_WIDTH(W), .G_NUM_REQ(N), .G_BURST(B)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (valid),
        .i_req_data  (data),
        .o_req_ready (ready),
        .o_gnt       (gnt),
        .o_busy      (busy),
        .o_fifo_wr   (wr),
        .o_fifo_data (fdata),
        .i_fifo_full (full)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic vbit(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            if (vbit(v, (p + i) % N)) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] word_of(input logic [N*W-1:0] d, input int k);
        logic [N*W-1:0] t;
        t = d >> (k * W);
        return t[W-1:0];
    endfunction

    task automatic model_reset();
        cur   = -1;
        last  = N - 1;
        beats = 0;
        ctl_q.delete();
        data_q.delete();
    endtask

    // One cycle per iteration: drive producers, record expected outputs, advance model.
    task automatic apply_stimulus(input int n, input int raise_pct, input int drop_pct, input int full_pct);
        ctl_t           e;
        logic [N*W-1:0] dv;
        logic           beat;
        int             g;
        repeat (n) begin
            @(posedge clk);
            #1;
            dv = '0;
            for (int k = 0; k < N; k++) begin
                if (!vbit(pend, k)) begin
                    if ($urandom_range(99) < raise_pct) pend = pend | (N'(1) << k);
                end else if ($urandom_range(99) < drop_pct) begin
                    pend = pend & ~(N'(1) << k);
                end
                dv = dv | ((N*W)'(((k << 6) | (seq[k] & 63))) << (k * W));
            end
            data  = dv;
            valid = pend;
            full  = ($urandom_range(99) < full_pct);

            e.gnt   = (cur >= 0) ? (N'(1) << cur) : '0;
            e.ready = (cur >= 0 && !full) ? (N'(1) << cur) : '0;
            e.busy  = (cur >= 0);
            ctl_q.push_back(e);

            g    = cur;
            beat = (cur >= 0) && !full && vbit(pend, cur);
            if (beat) data_q.push_back(word_of(dv, cur));

            if (cur < 0) begin
                if (|pend) begin
                    cur   = pick(last, pend);
                    beats = 0;
                end
            end else begin
                if (beat) beats++;
                if ((beat && beats == B) || !vbit(pend, cur)) begin
                    last  = cur;
                    beats = 0;
                    cur   = pick(last, pend);
                end
            end

            if (beat) begin
                pend   = pend & ~(N'(1) << g);
                seq[g] = seq[g] + 1;
            end
        end
    endtask

    // Monitor: compare control outputs every cycle and pop write data on each FIFO write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ctl_q.size() > 0) begin
                ctl_t e;
                e = ctl_q.pop_front();
                check_output("gnt", 32'(gnt), 32'(e.gnt));
                check_output("ready", 32'(ready), 32'(e.ready));
                check_output("busy", 32'(busy), 32'(e.busy));
            end
            if (wr) begin
                if (data_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_wr: got write of 0x%0h expected no write at %0t", fdata, $time);
                end else begin
                    check_output("wr_data", 32'(fdata), 32'(data_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        valid = '0;
        data  = '0;
        full  = 1'b0;
        pend  = '0;
        for (int k = 0; k < N; k++) seq[k] = 0;
        model_reset();

        #3;
        check_output("reset_gnt", 32'(gnt), 32'h0);
        check_output("reset_busy", 32'(busy), 32'h0);
        check_output("reset_ready", 32'(ready), 32'h0);
        check_output("reset_wr", 32'(wr), 32'h0);
        check_output("reset_data", 32'(fdata), 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(300, 40, 3, 10);
        apply_stimulus(200, 100, 0, 0);
        apply_stimulus(300, 60, 5, 40);
        apply_stimulus(40, 100, 0, 0);

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_gnt", 32'(gnt), 32'h0);
        check_output("async_rst_busy", 32'(busy), 32'h0);
        check_output("async_rst_ready", 32'(ready), 32'h0);
        check_output("async_rst_wr", 32'(wr), 32'h0);
        check_output("async_rst_data", 32'(fdata), 32'h0);
        valid = '0;
        pend  = '0;
        full  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(100, 100, 0, 0);
        apply_stimulus(300, 50, 8, 25);

        @(negedge clk);
        #1;
        check_output("scoreboard_drained", 32'(data_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO write port among G_NUM_REQ producers. Each producer has a valid/ready handshake. The block grants one producer at a time for bursts of up to G_BURST beats and muxes the granted producer's data onto the FIFO write port. It honours FIFO full, so the FIFO overflow flag can never assert. It sits directly in front of the FIFO in the FIFO's write clock domain.

## Interface
- G_WIDTH, 8: data width; must match the FIFO data width.
- G_NUM_REQ, 4: number of requesters, ≥ 2.
- G_BURST, 4: maximum beats per grant, 1..255.

Ports:
- i_clk, in, 1: single clock. All logic is on its rising edge.
- i_rst_n, in, 1: asynchronous, active-low reset.
- i_req_valid, in, G_NUM_REQ: per-requester valid.
- i_req_data, in, G_NUM_REQ*G_WIDTH: requester k's data occupies bits [k*G_WIDTH +: G_WIDTH].
- o_req_ready, out, G_NUM_REQ: per-requester ready; at most one bit set.
- o_gnt, out, G_NUM_REQ: registered one-hot grant, or all zero.
- o_busy, out, 1: high when the FSM is in GRANT.
- o_fifo_wr, out, 1: FIFO write enable.
- o_fifo_data, out, G_WIDTH: FIFO write data.
- i_fifo_full, in, 1: FIFO full flag.

## Operation
- State is r_state ∈ {IDLE, GRANT}, plus r_gnt (one-hot), r_ptr (index of the last grantee, ⌈log2 G_NUM_REQ⌉ bits) and r_cnt (beats accepted in the current grant, ⌈log2(G_BURST+1)⌉ bits).
- Combinational outputs:
  - o_req_ready = r_gnt & {G_NUM_REQ{!i_fifo_full}}.
  - o_fifo_wr = |(i_req_valid & o_req_ready).
  - o_fifo_data = data of the granted requester, or 0 when r_gnt = 0.
- A beat transfers in any cycle where valid[k] && ready[k].
- Selection function: the first requester with valid high, searching r_ptr+1, r_ptr+2, … modulo G_NUM_REQ and ending at r_ptr itself. The previous grantee can therefore win again only if no other requester is valid.
- IDLE:
  - If any valid bit is high, load r_gnt with the selection, clear r_cnt and go to GRANT.
  - Otherwise stay in IDLE with r_gnt = 0.
- GRANT, with grantee g:
  - A beat this cycle increments r_cnt.
  - The grant is released at the edge where either (a) a beat occurs and r_cnt+1 == G_BURST, or (b) valid[g] is low.
  - On release: r_ptr ← g and r_cnt ← 0. The selection (computed from the updated pointer, i.e. starting at g+1) loads r_gnt and the FSM stays in GRANT. For (a), valid[g] still counts as a candidate. If no requester is valid, go to IDLE with r_gnt ← 0.
  - While i_fifo_full is high, no beat occurs and r_cnt holds. The grant is held unless valid[g] drops.
- Producer rule: once valid is raised, the producer holds valid and data stable until ready. Dropping valid early gives up the grant (rule b).
- Reset: r_state = IDLE, r_gnt = 0, r_ptr = G_NUM_REQ−1 (so requester 0 has first priority), r_cnt = 0.
  - Output values in reset: o_gnt = 0, o_busy = 0, o_req_ready = 0, o_fifo_wr = 0, o_fifo_data = 0.
  - Reset asserts immediately and asynchronously, including mid-burst. The beat in flight is not written.

## Timing
- Grant latency: valid rising in cycle t while IDLE gives o_gnt and ready in cycle t+1. The first beat transfers in t+1 if the FIFO is not full.
- Sustained throughput is 1 beat/cycle within a burst.
- Handover after a G_BURST limit has zero bubble: the new grantee's ready is high in the cycle after the last beat of the old grant.
- A release because valid dropped costs exactly one idle cycle: the cycle in which valid is low.
- i_fifo_full → o_req_ready and o_fifo_wr are same-cycle combinational paths. The FIFO is never written while full.
- Writes leave in arrival order per requester. Beats from different grants never interleave within a burst.

## Test plan
- **Reset mid-burst:** requester 1 is granted with 2 beats done; drive i_rst_n=0 asynchronously → o_gnt, o_fifo_wr, o_busy and o_req_ready go to 0 immediately. After release with all four valid, requester 0 is granted first.
- **Single requester, G_BURST=4:** only requester 1 is valid, with 6 beats 0x10..0x15 → o_gnt=0b0010 from t+1. Six consecutive o_fifo_wr pulses with data 0x10..0x15. Re-grant to requester 1 at the 4-beat boundary with no bubble.
- **All four valid continuously:** grant order is 0,1,2,3,0, 4 cycles each. o_fifo_wr is high every cycle after the first.
- **FIFO full mid-burst:** i_fifo_full high for 3 cycles after beat 2 of requester 0 → ready=0, o_fifo_wr=0, r_cnt holds at 2, grant held. Beats 3 and 4 complete afterwards, then the grant rotates.
- **Early valid drop:** requester 0 drops valid after 1 beat while requester 2 is valid → one bubble cycle, then o_gnt=0b0100.
- **Pointer wrap:** requester 3 finishes while requesters 0 and 2 are valid → requester 0 is granted next, then requester 2.
